// File: rtl/pow2_pipe.sv
// pow2_pipe -- multi-cycle G.729 basic-op Pow2.
//
// Computes L_x = 2^(exponent + fraction/32768), bit-exact to the ITU G.729
// reference C: a 33-entry tabpow lookup, linear interpolation with L_msu,
// then a rounding shift L_shr_r(L_x, 30 - exponent).
//
// Ports:
//   clock     in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   start     in   1   request; accepted only in IDLE or DONE
//   exponent  in  16   signed integer part (Word16)
//   fraction  in  16   Q15 fractional part; bit 15 ignored
//   done      out  1   high while out holds a valid result
//   out       out 32   result L_x (Word32)
//
// start accepted on edge N gives done=1 and a valid out after edge N+4.
// The shifted value is registered in SHIFT and copied to out in LOAD, so out
// changes only on entry to DONE and the barrel shifter never drives out directly.

module pow2_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] exponent,
  input  logic [15:0] fraction,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MAC,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t             state;
  logic signed [15:0] exp_q;
  logic        [14:0] frac_q;
  logic        [15:0] t0_q;
  logic        [15:0] t1_q;
  logic        [14:0] a_q;
  logic signed [31:0] lx_q;
  logic signed [15:0] sh_q;
  logic        [31:0] res_q;

  // G.729 tab_ld8k tabpow: 2^(i/32) in Q14, i = 0..32.
  function automatic logic [15:0] tabpow(input logic [5:0] idx);
    logic [15:0] v;
    case (idx)
      6'd0:  v = 16'd16384;  6'd1:  v = 16'd16743;  6'd2:  v = 16'd17109;
      6'd3:  v = 16'd17484;  6'd4:  v = 16'd17867;  6'd5:  v = 16'd18258;
      6'd6:  v = 16'd18658;  6'd7:  v = 16'd19066;  6'd8:  v = 16'd19484;
      6'd9:  v = 16'd19911;  6'd10: v = 16'd20347;  6'd11: v = 16'd20792;
      6'd12: v = 16'd21247;  6'd13: v = 16'd21713;  6'd14: v = 16'd22188;
      6'd15: v = 16'd22674;  6'd16: v = 16'd23170;  6'd17: v = 16'd23678;
      6'd18: v = 16'd24196;  6'd19: v = 16'd24726;  6'd20: v = 16'd25268;
      6'd21: v = 16'd25821;  6'd22: v = 16'd26386;  6'd23: v = 16'd26964;
      6'd24: v = 16'd27554;  6'd25: v = 16'd28158;  6'd26: v = 16'd28774;
      6'd27: v = 16'd29405;  6'd28: v = 16'd30048;  6'd29: v = 16'd30706;
      6'd30: v = 16'd31379;  6'd31: v = 16'd32066;  6'd32: v = 16'd32767;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Interpolation: L_msu(t0<<16, t0-t1, a) = (t0<<16) - 2*(t0-t1)*a.
  // A 34-bit signed datapath holds the exact value before saturation.
  logic signed [33:0] t0_w;
  logic signed [33:0] t1_w;
  logic signed [33:0] a_w;
  logic signed [33:0] mult_w;
  logic signed [33:0] msu_w;
  logic signed [31:0] mac_sat;
  logic signed [16:0] sh_wide;
  logic signed [15:0] sh_sat;

  assign t0_w    = $signed({18'b0, t0_q});
  assign t1_w    = $signed({18'b0, t1_q});
  assign a_w     = $signed({19'b0, a_q});
  assign mult_w  = ((t0_w - t1_w) * a_w) <<< 1;
  assign msu_w   = (t0_w <<< 16) - mult_w;
  assign sh_wide = 17'sd30 - $signed({exp_q[15], exp_q});

  always_comb begin
    mac_sat = msu_w[31:0];
    if (msu_w[33:31] != 3'b000 && msu_w[33:31] != 3'b111) begin
      mac_sat = msu_w[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end

  // 30 - exponent only overflows Word16 on the positive side, but both
  // directions are clamped to mirror the sub() basic-op.
  always_comb begin
    sh_sat = sh_wide[15:0];
    if (sh_wide[16:15] == 2'b01) begin
      sh_sat = 16'sh7FFF;
    end else if (sh_wide[16:15] == 2'b10) begin
      sh_sat = 16'sh8000;
    end
  end

  // L_shr_r: rounding right shift for positive sh, saturating left shift
  // (L_shl) for negative sh. A left shift overflows when any bit shifted
  // across bit 31 differs from the sign.
  logic signed [31:0] shr_res;
  logic signed [31:0] rnd_w;
  logic        [63:0] wide_w;
  logic signed [16:0] neg_sh;
  logic         [4:0] sh5;
  logic         [4:0] n5;

  always_comb begin
    shr_res = '0;
    rnd_w   = '0;
    wide_w  = '0;
    sh5     = sh_q[4:0];
    neg_sh  = -$signed({sh_q[15], sh_q});
    n5      = neg_sh[4:0];
    if (sh_q > 16'sd31) begin
      shr_res = '0;
    end else if (sh_q > 16'sd0) begin
      rnd_w   = lx_q >>> (sh5 - 5'd1);
      shr_res = (lx_q >>> sh5) + {31'b0, rnd_w[0]};
    end else if (sh_q == 16'sd0) begin
      shr_res = lx_q;
    end else if (lx_q == 32'sd0) begin
      shr_res = '0;
    end else if (neg_sh > 17'sd30) begin
      shr_res = lx_q[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      wide_w = {{32{lx_q[31]}}, lx_q} << n5;
      if (wide_w[63:31] != {33{lx_q[31]}}) begin
        shr_res = lx_q[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      end else begin
        shr_res = wide_w[31:0];
      end
    end
  end

  // Sequencer: one step per state; start is honoured only in IDLE or DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      exp_q  <= '0;
      frac_q <= '0;
      t0_q   <= '0;
      t1_q   <= '0;
      a_q    <= '0;
      lx_q   <= '0;
      sh_q   <= '0;
      res_q  <= '0;
      done   <= 1'b0;
      out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q  <= exponent;
            frac_q <= fraction[14:0];
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          t0_q  <= tabpow({1'b0, frac_q[14:10]});
          t1_q  <= tabpow({1'b0, frac_q[14:10]} + 6'd1);
          a_q   <= {frac_q[9:0], 5'b0};
          state <= ST_MAC;
        end
        ST_MAC: begin
          lx_q  <= mac_sat;
          sh_q  <= sh_sat;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          res_q <= shr_res;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          out   <= res_q;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            done   <= 1'b0;
            exp_q  <= exponent;
            frac_q <= fraction[14:0];
            state  <= ST_READ;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
